capture_arbiter: RTL and testbench
==================================

CAPTURE_ARBITER -- requirements
Module: capture_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of event requesters (2..16) SHALL be supported.
REQ-002 Parameter DATA_W, default 32, event payload width.
REQ-003 Parameter FIFO_DEPTH, default 4, output buffer entries; power of two, >= 2.
REQ-004 Parameter ERR_LIMIT, default 8, error count that triggers drain when enabled; range 1..65535.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 req_valid  in  NUM_REQ  per-requester event present.
REQ-008 req_ready  out  NUM_REQ  per-requester grant; at most one bit high.
REQ-009 req_level  in  NUM_REQ*3  per-requester tone: TRACE=0, DEBUG=1, INFO=2, WARN=3, ERROR=4, FATAL=5.
REQ-010 req_data  in  NUM_REQ*DATA_W  per-requester payload.
REQ-011 min_level  in  3  forwarding threshold.
REQ-012 log_valid  out  1  buffered event available.
REQ-013 log_ready  in  1  downstream logger accepts.
REQ-014 log_level / log_src / log_data / log_seq  out  3 / clog2(NUM_REQ) / DATA_W / 16  head event fields.
REQ-015 err_count  out  16  accepted ERROR+FATAL events.
REQ-016 halt  out  1  simulation-complete flag.

Function
REQ-017 Request handshake SHALL be req_valid[i] & req_ready[i]; downstream handshake SHALL be log_valid & log_ready.
REQ-018 Arbitration SHALL be round-robin, searching from pointer rr_ptr upward with wrap; the first valid requester gets req_ready in the same cycle (combinational from req_valid, rr_ptr, FIFO state, FSM state).
REQ-019 After an accepted request from i, rr_ptr SHALL become (i+1) mod NUM_REQ; with no acceptance, rr_ptr SHALL hold.
REQ-020 No grant SHALL be issued while the FIFO is full at the start of the cycle, even if a pop occurs that cycle.
REQ-021 Accepted event SHALL be pushed if level >= min_level or level == FATAL; otherwise it is accepted and discarded (filtered).
REQ-022 Pushed entry SHALL carry level, source index, data, and current seq; seq increments by 1 per push, wrapping 0xFFFF->0.
REQ-023 Latency: an event accepted in cycle N SHALL appear at the FIFO head no earlier than cycle N+1; FIFO order SHALL be preserved.
REQ-024 Simultaneous push and pop SHALL both occur; occupancy unchanged.
REQ-025 err_count SHALL increment on every accepted level >= 4, filtered or not, saturating at 0xFFFF.
REQ-026 FSM states: RUN, DRAIN, HALTED.
REQ-027 RUN: grants enabled; accepted FATAL -> DRAIN next cycle.
REQ-028 DRAIN: no grants; FIFO continues to pop; FIFO empty -> HALTED.
REQ-029 HALTED: no grants, log_valid=0, halt=1; exit only by reset.
REQ-030 Levels 6 and 7 on req_level SHALL be treated as FATAL.

Reset
REQ-031 While rst_n=0 at a clock edge: state RUN, rr_ptr=0, FIFO empty, seq=0, err_count=0, halt=0.
REQ-032 During reset cycle outputs SHALL be req_ready=0, log_valid=0, log_level=0, log_src=0, log_data=0, log_seq=0.
REQ-033 Reset mid-operation SHALL discard all buffered events and counts regardless of state.

Configuration
REQ-034 Macro CAPTURE_ARBITER_ERR_LIMIT_EN defined: in RUN, err_count reaching ERR_LIMIT via an accepted event SHALL transition to DRAIN next cycle, identical to FATAL.
REQ-035 Macro undefined: only FATAL triggers DRAIN; err_count still counts; ERR_LIMIT is unused.

Verification
REQ-036 Reqs 0,2,3 held valid at INFO, min_level=0, log_ready=1 -> accepts in order 0,2,3,0,2,3; log_seq 0,1,2,...
REQ-037 log_ready=0, all 4 valid, FIFO_DEPTH=4 -> exactly 4 accepts, then req_ready=0 until pop; no data loss on release.
REQ-038 min_level=3, req1 sends DEBUG then WARN -> both accepted, only WARN forwarded with log_seq=0; err_count=0.
REQ-039 Req2 sends FATAL with 2 entries buffered -> no grants next cycle, 3 events drain, then halt=1 and stays 1.
REQ-040 Macro defined, ERR_LIMIT=3, three ERROR events -> DRAIN after the third; macro undefined -> continues RUN, err_count=3.
REQ-041 rst_n=0 for one cycle during DRAIN with full FIFO -> log_valid=0, halt=0, err_count=0, next grant to requester 0 first.

Source files
------------

// File: rtl/capture_arbiter.sv
// capture_arbiter
//   Round-robin arbiter that collects log events from NUM_REQ requesters,
//   filters them against a level threshold and queues the survivors in a
//   small FIFO for a downstream logger.
//   An accepted FATAL event stops new grants, drains the FIFO and then
//   raises halt.
//
// Parameters
//   NUM_REQ    number of requesters (2..16)
//   DATA_W     payload width
//   FIFO_DEPTH output buffer entries (power of two, >= 2)
//   ERR_LIMIT  ERROR/FATAL count that starts a drain when the limit feature is built in
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   req_valid / req_ready        per-requester handshake (req_ready is one-hot or zero)
//   req_level / req_data         per-requester level (3 bits each) and payload
//   min_level                    forwarding threshold
//   log_valid / log_ready        downstream handshake
//   log_level / log_src /
//   log_data / log_seq           fields of the FIFO head entry
//   err_count                    saturating count of accepted ERROR and FATAL events
//   halt                         set once the drain has completed
//
// Build option
//   CAPTURE_ARBITER_ERR_LIMIT_EN  when defined, err_count reaching ERR_LIMIT
//                                 through an accepted event starts a drain,
//                                 just like FATAL does.
//
// State   | meaning
// --------+------------------------------------------------------------
// RUN     | grants enabled, events buffered and forwarded
// DRAIN   | grants blocked, FIFO keeps emptying toward the logger
// HALTED  | everything stopped, halt=1 until reset
module capture_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_LIMIT  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*3-1:0]       req_level,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [2:0]                 min_level,
    output logic                       log_valid,
    input  logic                       log_ready,
    output logic [2:0]                 log_level,
    output logic [$clog2(NUM_REQ)-1:0] log_src,
    output logic [DATA_W-1:0]          log_data,
    output logic [15:0]                log_seq,
    output logic [15:0]                err_count,
    output logic                       halt
);
    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    localparam logic [2:0]       LVL_ERROR   = 3'd4;
    localparam logic [2:0]       LVL_FATAL   = 3'd5;
    localparam logic [15:0]      ERR_LIMIT_C = 16'(ERR_LIMIT);
    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);

`ifdef CAPTURE_ARBITER_ERR_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      seq_q, seq_d;
    logic [15:0]      err_count_q, err_count_d;
    logic             halt_q, halt_d;

    logic [2:0]        fifo_level_q [FIFO_DEPTH];
    logic [SRC_W-1:0]  fifo_src_q   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q  [FIFO_DEPTH];
    logic [15:0]       fifo_seq_q   [FIFO_DEPTH];

    logic              grant_found;
    logic [SRC_W-1:0]  grant_idx;
    int                cand;
    logic              grant_en;
    logic              accept;
    logic              push;
    logic              pop;
    logic              is_fatal;
    logic              err_inc;
    logic              limit_hit;
    logic [2:0]        acc_level_raw;
    logic [2:0]        acc_level;
    logic [DATA_W-1:0] acc_data;

    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && req_valid[SRC_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = SRC_W'(cand);
            end
        end
    end

    always_comb begin
        acc_level_raw = '0;
        acc_data      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                acc_level_raw = req_level[i*3 +: 3];
                acc_data      = req_data[i*DATA_W +: DATA_W];
            end
        end

        // Fullness is judged on the registered count, so a pop in the same
        // cycle never frees a slot for a grant until the next cycle.
        grant_en  = rst_n && (state_q == ST_RUN) && (count_q != DEPTH_C);
        accept    = grant_en && grant_found;
        req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

        // Levels 6 and 7 are folded into FATAL.
        is_fatal  = (acc_level_raw >= LVL_FATAL);
        acc_level = is_fatal ? LVL_FATAL : acc_level_raw;
        push      = accept && (is_fatal || (acc_level >= min_level));
        err_inc   = accept && (acc_level_raw >= LVL_ERROR);

        log_valid = rst_n && (count_q != '0) && (state_q != ST_HALTED);
        pop       = log_valid && log_ready;

        log_level = log_valid ? fifo_level_q[rd_ptr_q] : '0;
        log_src   = log_valid ? fifo_src_q[rd_ptr_q]   : '0;
        log_data  = log_valid ? fifo_data_q[rd_ptr_q]  : '0;
        log_seq   = log_valid ? fifo_seq_q[rd_ptr_q]   : '0;

        err_count_d = err_count_q;
        if (err_inc && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
        limit_hit = LIMIT_EN && err_inc && (err_count_d == ERR_LIMIT_C);

        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        seq_d    = push ? seq_q + 16'd1     : seq_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept && (is_fatal || limit_hit)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_q == '0) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
        halt_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            seq_q       <= '0;
            err_count_q <= '0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            seq_q       <= seq_d;
            err_count_q <= err_count_d;
            halt_q      <= halt_d;
            if (push) begin
                fifo_level_q[wr_ptr_q] <= acc_level;
                fifo_src_q[wr_ptr_q]   <= grant_idx;
                fifo_data_q[wr_ptr_q]  <= acc_data;
                fifo_seq_q[wr_ptr_q]   <= seq_q;
            end
        end
    end

    assign err_count = err_count_q;
    assign halt      = halt_q;

endmodule

// File: tb/tb_capture_arbiter.sv
// Directed bench for capture_arbiter: round-robin order, FIFO back-pressure,
// level filtering, FATAL drain to halt, error-limit option and mid-drain reset.
module tb_capture_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int ERR_LIMIT  = 3;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*3-1:0]      req_level;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [2:0]                min_level;
    logic                      log_valid;
    logic                      log_ready;
    logic [2:0]                log_level;
    logic [1:0]                log_src;
    logic [DATA_W-1:0]         log_data;
    logic [15:0]               log_seq;
    logic [15:0]               err_count;
    logic                      halt;

    int n_checks = 0;
    int n_pass   = 0;

    capture_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ERR_LIMIT  (ERR_LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_level (req_level),
        .req_data  (req_data),
        .min_level (min_level),
        .log_valid (log_valid),
        .log_ready (log_ready),
        .log_level (log_level),
        .log_src   (log_src),
        .log_data  (log_data),
        .log_seq   (log_seq),
        .err_count (err_count),
        .halt      (halt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lvl(input int i, input logic [2:0] l);
        req_level[i*3 +: 3] = l;
    endtask

    task automatic all_lvl(input logic [2:0] l);
        for (int i = 0; i < NUM_REQ; i++) begin
            set_lvl(i, l);
        end
    endtask

    // Waits 1 ns into the cycle, then checks grant and head fields.
    task automatic expect_cyc(input string tag, input int rdy, input bit lv, input int src, input int seq);
        #1;
        check_eq({tag, ".rdy"}, 32'(req_ready), rdy);
        check_eq({tag, ".lv"}, 32'(log_valid), 32'(lv));
        if (lv) begin
            check_eq({tag, ".src"}, 32'(log_src), src);
            check_eq({tag, ".seq"}, 32'(log_seq), seq);
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        req_valid = '1;
        log_ready = 1'b1;
        min_level = 3'd0;
        all_lvl(3'd2);
        #1;
        check_eq({tag, ".rdy"}, 32'(req_ready), 0);
        check_eq({tag, ".lv"}, 32'(log_valid), 0);
        check_eq({tag, ".lvl"}, 32'(log_level), 0);
        check_eq({tag, ".src"}, 32'(log_src), 0);
        check_eq({tag, ".data"}, log_data, 0);
        check_eq({tag, ".seq"}, 32'(log_seq), 0);
        tick();
        tick();
        check_eq({tag, ".halt"}, 32'(halt), 0);
        check_eq({tag, ".err"}, 32'(err_count), 0);
        rst_n     = 1'b1;
        req_valid = '0;
        log_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[6];
        int prev;
        int exp_rdy;

        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = 32'hC0DE_0000 + i;
        end
        req_level = '0;

        // Round robin over requesters 0,2,3 with immediate forwarding.
        do_reset("rstA");
        log_ready = 1'b1;
        req_valid = 4'b1101;
        order = '{0, 2, 3, 0, 2, 3};
        prev  = 0;
        for (int k = 0; k < 6; k++) begin
            expect_cyc($sformatf("rr%0d", k), 1 << order[k], k > 0, prev, k - 1);
            prev = order[k];
            tick();
        end
        req_valid = '0;
        expect_cyc("rr_tail", 0, 1'b1, 3, 5);
        tick();
        expect_cyc("rr_empty", 0, 1'b0, 0, 0);
        tick();

        // Back-pressure: four accepts fill the FIFO, then nothing until a pop.
        do_reset("rstB");
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            expect_cyc($sformatf("fill%0d", k), 1 << k, k > 0, 0, 0);
            tick();
        end
        expect_cyc("full0", 0, 1'b1, 0, 0);
        tick();
        expect_cyc("full1", 0, 1'b1, 0, 0);
        tick();
        log_ready = 1'b1;
        expect_cyc("full_pop", 0, 1'b1, 0, 0);
        check_eq("full_pop.data", log_data, 32'hC0DE_0000);
        tick();
        expect_cyc("refill", 1, 1'b1, 1, 1);
        check_eq("refill.data", log_data, 32'hC0DE_0001);
        tick();
        req_valid = '0;
        expect_cyc("drainB2", 0, 1'b1, 2, 2);
        tick();
        expect_cyc("drainB3", 0, 1'b1, 3, 3);
        check_eq("drainB3.data", log_data, 32'hC0DE_0003);
        tick();
        expect_cyc("drainB4", 0, 1'b1, 0, 4);
        check_eq("drainB4.data", log_data, 32'hC0DE_0000);
        tick();
        expect_cyc("drainB5", 0, 1'b0, 0, 0);
        tick();

        // Filtering: DEBUG dropped, WARN forwarded with seq 0.
        do_reset("rstC");
        min_level = 3'd3;
        log_ready = 1'b1;
        req_valid = 4'b0010;
        set_lvl(1, 3'd1);
        expect_cyc("flt_dbg", 2, 1'b0, 0, 0);
        tick();
        set_lvl(1, 3'd3);
        expect_cyc("flt_warn", 2, 1'b0, 0, 0);
        tick();
        req_valid = '0;
        expect_cyc("flt_out", 0, 1'b1, 1, 0);
        check_eq("flt_out.lvl", 32'(log_level), 3);
        check_eq("flt_out.err", 32'(err_count), 0);
        tick();

        // FATAL (encoded as 6) with two entries buffered drains three, then halts.
        do_reset("rstD");
        req_valid = 4'b0001;
        expect_cyc("ftl_a", 1, 1'b0, 0, 0);
        tick();
        req_valid = 4'b0010;
        expect_cyc("ftl_b", 2, 1'b1, 0, 0);
        tick();
        req_valid = 4'b0100;
        set_lvl(2, 3'd6);
        expect_cyc("ftl_c", 4, 1'b1, 0, 0);
        tick();
        req_valid = 4'b1111;
        log_ready = 1'b1;
        expect_cyc("drn0", 0, 1'b1, 0, 0);
        tick();
        expect_cyc("drn1", 0, 1'b1, 1, 1);
        tick();
        expect_cyc("drn2", 0, 1'b1, 2, 2);
        check_eq("drn2.lvl", 32'(log_level), 5);
        tick();
        expect_cyc("drn3", 0, 1'b0, 0, 0);
        check_eq("drn3.halt", 32'(halt), 0);
        tick();
        expect_cyc("halt0", 0, 1'b0, 0, 0);
        check_eq("halt0.halt", 32'(halt), 1);
        repeat (5) tick();
        expect_cyc("halt1", 0, 1'b0, 0, 0);
        check_eq("halt1.halt", 32'(halt), 1);
        check_eq("halt1.err", 32'(err_count), 1);

        // Reset in DRAIN with a full FIFO.
        tick();
        do_reset("rstE");
        all_lvl(3'd2);
        set_lvl(3, 3'd7);
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            expect_cyc($sformatf("fillE%0d", k), 1 << k, k > 0, 0, 0);
            tick();
        end
        expect_cyc("drnE", 0, 1'b1, 0, 0);
        check_eq("drnE.err", 32'(err_count), 1);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("midrst.lv", 32'(log_valid), 0);
        check_eq("midrst.rdy", 32'(req_ready), 0);
        check_eq("midrst.data", log_data, 0);
        check_eq("midrst.lvl", 32'(log_level), 0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("postrst.halt", 32'(halt), 0);
        check_eq("postrst.err", 32'(err_count), 0);
        check_eq("postrst.lv", 32'(log_valid), 0);
        check_eq("postrst.rdy", 32'(req_ready), 1);
        tick();

        // Three ERROR events against ERR_LIMIT=3.
        do_reset("rstF");
        log_ready = 1'b1;
        set_lvl(0, 3'd4);
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("err%0d.rdy", k), 32'(req_ready), 1);
            tick();
        end
`ifdef CAPTURE_ARBITER_ERR_LIMIT_EN
        exp_rdy = 0;
`else
        exp_rdy = 1;
`endif
        #1;
        check_eq("errlim.rdy", 32'(req_ready), exp_rdy);
        check_eq("errlim.err", 32'(err_count), 3);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
